// File: rtl/csr_hazard_ctrl.sv
// Hazard controller for the CSR path: read-after-write stalls against an
// internal E/M/W write scoreboard, memory-miss freezes and branch squashes.
module csr_hazard_ctrl #(
    parameter int CSR_AW = 12,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_csr_rd,
    input  logic              id_csr_wr,
    input  logic [CSR_AW-1:0] id_csr_addr,
    input  logic              br_ex,
    input  logic              mem_miss,
    input  logic              mem_done,
    output logic              bubbleF,
    output logic              bubbleD,
    output logic              bubbleE,
    output logic              bubbleM,
    output logic              bubbleW,
    output logic              flushD,
    output logic              flushE,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic {RUN, MISS} state_e;

    state_e            state_q, state_d;
    logic              e_v_q, e_v_d, m_v_q, m_v_d, w_v_q, w_v_d;
    logic [CSR_AW-1:0] e_addr_q, e_addr_d, m_addr_q, m_addr_d, w_addr_q, w_addr_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic              freeze, csr_haz, any_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            e_v_q          <= 1'b0;
            m_v_q          <= 1'b0;
            w_v_q          <= 1'b0;
            e_addr_q       <= '0;
            m_addr_q       <= '0;
            w_addr_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            e_v_q          <= e_v_d;
            m_v_q          <= m_v_d;
            w_v_q          <= w_v_d;
            e_addr_q       <= e_addr_d;
            m_addr_q       <= m_addr_d;
            w_addr_q       <= w_addr_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mem_miss) state_d = MISS;
            MISS:    if (mem_done) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // The mem_done cycle itself is not frozen, so freeze looks at the pulse.
    always_comb begin
        freeze = 1'b0;
        if (!rst) begin
            freeze = (state_q == RUN  &&  mem_miss) ||
                     (state_q == MISS && !mem_done);
        end
    end

    // No bypass into the CSR file: a write still sitting in W must block too.
    always_comb begin
        csr_haz = id_valid && id_csr_rd &&
                  ((e_v_q && e_addr_q == id_csr_addr) ||
                   (m_v_q && m_addr_q == id_csr_addr) ||
                   (w_v_q && w_addr_q == id_csr_addr));
    end

    always_comb begin
        bubbleF = 1'b0;
        bubbleD = 1'b0;
        bubbleE = 1'b0;
        bubbleM = 1'b0;
        bubbleW = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        if (rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (freeze) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            bubbleE = 1'b1;
            bubbleM = 1'b1;
            bubbleW = 1'b1;
        end else if (br_ex) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (csr_haz) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
        end
    end

    // Slots follow the same hold/flush controls as the real segment registers.
    always_comb begin
        e_v_d    = e_v_q;
        e_addr_d = e_addr_q;
        m_v_d    = m_v_q;
        m_addr_d = m_addr_q;
        w_v_d    = w_v_q;
        w_addr_d = w_addr_q;
        if (!bubbleW) begin
            w_v_d    = m_v_q;
            w_addr_d = m_addr_q;
        end
        if (!bubbleM) begin
            m_v_d    = e_v_q;
            m_addr_d = e_addr_q;
        end
        if (!bubbleE) begin
            if (flushE) begin
                e_v_d    = 1'b0;
                e_addr_d = '0;
            end else begin
                e_v_d    = id_valid && id_csr_wr;
                e_addr_d = id_csr_addr;
            end
        end
    end

    always_comb begin
        any_bubble     = bubbleF | bubbleD | bubbleE | bubbleM | bubbleW;
        stall_cycles_d = stall_cycles_q + CNT_W'(any_bubble);
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_csr_hazard_ctrl.sv
// Directed self-checking bench for csr_hazard_ctrl: RAW stalls, branch
// squash, miss freeze and reset during a miss.
module tb_csr_hazard_ctrl;

    localparam int CSR_AW = 12;
    localparam int CNT_W  = 32;

    // {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushD, flushE}
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_HAZ  = 7'b1100001;
    localparam logic [6:0] O_FRZ  = 7'b1111100;
    localparam logic [6:0] O_SQSH = 7'b0000011;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_csr_rd, id_csr_wr;
    logic [CSR_AW-1:0] id_csr_addr;
    logic              br_ex, mem_miss, mem_done;
    logic              bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic              flushD, flushE;
    logic [CNT_W-1:0]  stall_cycles;
    logic [6:0]        obs;

    int checks = 0;
    int errors = 0;

    csr_hazard_ctrl #(.CSR_AW(CSR_AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_csr_rd    (id_csr_rd),
        .id_csr_wr    (id_csr_wr),
        .id_csr_addr  (id_csr_addr),
        .br_ex        (br_ex),
        .mem_miss     (mem_miss),
        .mem_done     (mem_done),
        .bubbleF      (bubbleF),
        .bubbleD      (bubbleD),
        .bubbleE      (bubbleE),
        .bubbleM      (bubbleM),
        .bubbleW      (bubbleW),
        .flushD       (flushD),
        .flushE       (flushE),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    assign obs = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushD, flushE};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic rd, input logic wr,
                          input logic [CSR_AW-1:0] a);
        id_valid    = v;
        id_csr_rd   = rd;
        id_csr_wr   = wr;
        id_csr_addr = a;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        br_ex    = 1'b0;
        mem_miss = 1'b0;
        mem_done = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        br_ex    = 1'b0;
        mem_miss = 1'b0;
        mem_done = 1'b0;
        set_id(1'b1, 1'b1, 1'b0, 12'h300);
        tick();
        @(negedge clk);
        checks++;
        if (obs !== O_SQSH) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", obs, O_SQSH);
        end
        checks++;
        if (stall_cycles !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", stall_cycles);
        end
        tick();
        rst = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", obs, O_IDLE);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(1'b1, 1'b1, 1'b1, 12'h300);
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL b2b_write: got %b want %b", obs, O_IDLE);
        end
        tick();
        set_id(1'b1, 1'b1, 1'b0, 12'h300);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== O_HAZ) begin
                errors++;
                $display("FAIL b2b_stall%0d: got %b want %b", i, obs, O_HAZ);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL b2b_release: got %b want %b", obs, O_IDLE);
        end
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", stall_cycles);
        end
        tick();
        set_id(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_diff_addr();
        do_reset();
        set_id(1'b1, 1'b1, 1'b1, 12'h300);
        tick();
        set_id(1'b1, 1'b1, 1'b0, 12'h305);
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL diff_addr: got %b want %b", obs, O_IDLE);
        end
        tick();
        set_id(1'b1, 1'b0, 1'b1, 12'h300);
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL no_read: got %b want %b", obs, O_IDLE);
        end
        tick();
        set_id(1'b0, 1'b1, 1'b1, 12'h3a0);
        tick();
        set_id(1'b1, 1'b1, 1'b0, 12'h3a0);
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL invalid_write: got %b want %b", obs, O_IDLE);
        end
        checks++;
        if (stall_cycles !== '0) begin
            errors++;
            $display("FAIL diff_count: got %0d want 0", stall_cycles);
        end
        tick();
        set_id(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_branch_write();
        do_reset();
        set_id(1'b1, 1'b1, 1'b1, 12'h341);
        br_ex = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== O_SQSH) begin
            errors++;
            $display("FAIL br_write: got %b want %b", obs, O_SQSH);
        end
        tick();
        br_ex = 1'b0;
        set_id(1'b1, 1'b1, 1'b0, 12'h341);
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL br_read_after: got %b want %b", obs, O_IDLE);
        end
        tick();
        set_id(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_branch_haz();
        do_reset();
        set_id(1'b1, 1'b1, 1'b1, 12'h300);
        tick();
        set_id(1'b1, 1'b1, 1'b0, 12'h300);
        br_ex = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== O_SQSH) begin
            errors++;
            $display("FAIL br_over_haz: got %b want %b", obs, O_SQSH);
        end
        tick();
        br_ex = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (stall_cycles !== '0) begin
            errors++;
            $display("FAIL br_count: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_miss();
        do_reset();
        set_id(1'b1, 1'b1, 1'b1, 12'h300);
        tick();
        set_id(1'b1, 1'b1, 1'b0, 12'h300);
        mem_miss = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== O_FRZ) begin
                errors++;
                $display("FAIL miss_freeze%0d: got %b want %b", i, obs, O_FRZ);
            end
            tick();
            mem_miss = 1'b0;
            br_ex    = (i == 1);
        end
        br_ex    = 1'b0;
        mem_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== O_HAZ) begin
                errors++;
                $display("FAIL miss_haz%0d: got %b want %b", i, obs, O_HAZ);
            end
            tick();
            mem_done = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL miss_release: got %b want %b", obs, O_IDLE);
        end
        checks++;
        if (stall_cycles !== 32'd7) begin
            errors++;
            $display("FAIL miss_count: got %0d want 7", stall_cycles);
        end
        tick();
        set_id(1'b0, 1'b0, 1'b0, '0);
        mem_done = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL done_in_run: got %b want %b", obs, O_IDLE);
        end
        tick();
        mem_done = 1'b0;
    endtask

    task automatic test_reset_in_miss();
        do_reset();
        mem_miss = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== O_FRZ) begin
            errors++;
            $display("FAIL rm_freeze: got %b want %b", obs, O_FRZ);
        end
        tick();
        mem_miss = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== O_SQSH) begin
            errors++;
            $display("FAIL rm_rst: got %b want %b", obs, O_SQSH);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL rm_after: got %b want %b", obs, O_IDLE);
        end
        checks++;
        if (stall_cycles !== '0) begin
            errors++;
            $display("FAIL rm_count: got %0d want 0", stall_cycles);
        end
        tick();
        mem_done = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL rm_done: got %b want %b", obs, O_IDLE);
        end
        tick();
        mem_done = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL rm_done_after: got %b want %b", obs, O_IDLE);
        end
        tick();
        mem_miss = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== O_FRZ) begin
            errors++;
            $display("FAIL rm_new_miss: got %b want %b", obs, O_FRZ);
        end
        tick();
        mem_miss = 1'b0;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_diff_addr();
        test_branch_write();
        test_branch_haz();
        test_miss();
        test_reset_in_miss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
